nonce_scheduler: RTL and testbench

//  Job-level controller wrapped around the varminer hashing array. Accepts one block-header job
//  and a nonce range, then feeds the array NUM_HASHERS consecutive nonces per batch.

---
 rtl/nonce_scheduler_pkg.sv | 36 +++
 rtl/nonce_scheduler_target_expand.sv | 14 +
 rtl/nonce_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_scheduler_pkg.sv
// Shared types and helpers for the nonce scheduler around the hashing array.
package miner_pkg;

   localparam int NONCE_W = 32;
   localparam int HASH_W  = 256;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      CHECK   = 3'd3,
      REPORT  = 3'd4,
      ADVANCE = 3'd5,
      DONE    = 3'd6
   } sched_state_t;

   // Compact 'bits' to a 256-bit target. Shifts past the word simply fall off,
   // which gives the required truncation. A set mantissa sign bit means "no target".
   function automatic logic [HASH_W-1:0] expand_target(input logic [31:0] bits);
      logic [7:0]        e;
      logic [HASH_W-1:0] m;
      logic [10:0]       sh;
      e = bits[31:24];
      m = HASH_W'(bits[23:0]);
      if (bits[23]) begin
         return '0;
      end
      if (e >= 8'd3) begin
         sh = {e - 8'd3, 3'b000};
         return m << sh;
      end
      sh = {8'd3 - e, 3'b000};
      return m >> sh;
   endfunction

endpackage

// File: rtl/nonce_scheduler_target_expand.sv
// Combinational compact-bits to target expansion; the scheduler registers it at job accept.
module target_expand
   import miner_pkg::*;
(
   input  logic [31:0]       bits,
   output logic [HASH_W-1:0] target,
   output logic              target_neg
);

   assign target     = expand_target(bits);
   // A negative compact target must block every hit, even a zero digest.
   assign target_neg = bits[23];

endmodule

// File: rtl/nonce_scheduler.sv
// Job-level controller: feeds the hashing array batches of consecutive nonces,
// scans the returned digests lane by lane and reports every hit over valid/ready.
module nonce_scheduler
   import miner_pkg::*;
#(
   parameter int NUM_HASHERS = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [31:0]                   version,
   input  logic [255:0]                  hashPrevBlock,
   input  logic [255:0]                  hashMerkleRoot,
   input  logic [31:0]                   timestamp,
   input  logic [31:0]                   bits,
   input  logic [31:0]                   nonce_start,
   input  logic [31:0]                   nonce_end,
   input  logic                          abort,
   output logic [31:0]                   hdr_version,
   output logic [255:0]                  hdr_hashPrevBlock,
   output logic [255:0]                  hdr_hashMerkleRoot,
   output logic [31:0]                   hdr_timestamp,
   output logic [31:0]                   hdr_bits,
   output logic [NUM_HASHERS*32-1:0]     miner_nonce,
   output logic                          miner_start,
   output logic                          miner_reset,
   input  logic                          miner_done,
   input  logic [NUM_HASHERS*256-1:0]    miner_hash,
   output logic                          found_valid,
   input  logic                          found_ready,
   output logic [31:0]                   found_nonce,
   output logic [255:0]                  found_hash,
   output logic                          busy,
   output logic                          exhausted
);

   // Lane index must also hold NUM_HASHERS (the "past last lane" value after a final report).
   localparam int                LANE_W    = $clog2(NUM_HASHERS) + 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_HASHERS - 1);

   sched_state_t                     state;
   logic [LANE_W-1:0]                lane;
   logic [NONCE_W-1:0]               base;
   logic [NONCE_W-1:0]               range_end;
   logic [HASH_W-1:0]                target;
   logic                             target_neg;
   logic [NUM_HASHERS*HASH_W-1:0]    hash_buf;

   logic [HASH_W-1:0]                target_exp;
   logic                             target_neg_exp;
   logic [NONCE_W-1:0]               fill_base;
   logic [NUM_HASHERS*NONCE_W-1:0]   fill_vec;
   int                               lane_sel;
   logic [HASH_W-1:0]                lane_hash;
   logic [NONCE_W:0]                 lane_nonce;
   logic [NONCE_W:0]                 batch_last;
   logic                             lane_hit;
   logic                             batch_final;
   logic                             job_accept;

   target_expand u_target_expand (
      .bits       (bits),
      .target     (target_exp),
      .target_neg (target_neg_exp)
   );

   assign job_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign job_accept = (state == IDLE) && job_valid && !abort;

   // Nonce vector for the next batch: range start at accept, base+NUM_HASHERS on advance.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      fill_vec  = '0;
      fill_base = (state == IDLE) ? nonce_start : base + NONCE_W'(NUM_HASHERS);
      for (int i = 0; i < NUM_HASHERS; i++) begin
         fill_vec[i*NONCE_W +: NONCE_W] = fill_base + NONCE_W'(i);
      end
   end

   // Hit test for the current lane plus the end-of-range test for the whole batch.
   always_comb begin
      lane_sel    = (int'(lane) < NUM_HASHERS) ? int'(lane) : 0;
      lane_hash   = hash_buf[lane_sel*HASH_W +: HASH_W];
      lane_nonce  = {1'b0, base} + (NONCE_W+1)'(lane);
      batch_last  = {1'b0, base} + (NONCE_W+1)'(NUM_HASHERS - 1);
      lane_hit    = !lane_nonce[NONCE_W] && (lane_nonce[NONCE_W-1:0] <= range_end) &&
                    !target_neg && (lane_hash <= target);
      batch_final = batch_last[NONCE_W] || (batch_last[NONCE_W-1:0] >= range_end);
   end

   // Scheduler FSM and all registered outputs; abort overrides every transition.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the digest buffer and job registers are reset as well, so the
         // compare path never sees X after a mid-job reset.
         state              <= IDLE;
         lane               <= '0;
         base               <= '0;
         range_end          <= '0;
         target             <= '0;
         target_neg         <= 1'b0;
         hash_buf           <= '0;
         hdr_version        <= '0;
         hdr_hashPrevBlock  <= '0;
         hdr_hashMerkleRoot <= '0;
         hdr_timestamp      <= '0;
         hdr_bits           <= '0;
         miner_nonce        <= '0;
         miner_start        <= 1'b0;
         miner_reset        <= 1'b1;
         found_valid        <= 1'b0;
         found_nonce        <= '0;
         found_hash         <= '0;
         exhausted          <= 1'b0;
      end else if (abort && state != IDLE) begin
         // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
         state       <= IDLE;
         miner_start <= 1'b0;
         miner_reset <= 1'b1;
         found_valid <= 1'b0;
         exhausted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               miner_reset <= 1'b1;
               exhausted   <= 1'b0;
               if (job_accept) begin
                  hdr_version        <= version;
                  hdr_hashPrevBlock  <= hashPrevBlock;
                  hdr_hashMerkleRoot <= hashMerkleRoot;
                  hdr_timestamp      <= timestamp;
                  hdr_bits           <= bits;
                  target             <= target_exp;
                  target_neg         <= target_neg_exp;
                  base               <= nonce_start;
                  range_end          <= nonce_end;
                  miner_nonce        <= fill_vec;
                  if (nonce_end < nonce_start) begin
                     exhausted <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CLEAR;
                  end
               end
            end
            CLEAR: begin
               miner_reset <= 1'b0;
               miner_start <= 1'b1;
               state       <= RUN;
            end
            RUN: begin
               if (miner_done) begin
                  hash_buf    <= miner_hash;
                  lane        <= '0;
                  miner_start <= 1'b0;
                  state       <= CHECK;
               end
            end
            CHECK: begin
               if (lane <= LAST_LANE && lane_hit) begin
                  found_valid <= 1'b1;
                  found_nonce <= lane_nonce[NONCE_W-1:0];
                  found_hash  <= lane_hash;
                  state       <= REPORT;
               end else if (lane >= LAST_LANE) begin
                  if (batch_final) begin
                     exhausted   <= 1'b1;
                     miner_reset <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= ADVANCE;
                  end
               end else begin
                  lane <= lane + 1'b1;
               end
            end
            REPORT: begin
               if (found_ready) begin
                  found_valid <= 1'b0;
                  lane        <= lane + 1'b1;
                  state       <= CHECK;
               end
            end
            ADVANCE: begin
               base        <= base + NONCE_W'(NUM_HASHERS);
               miner_nonce <= fill_vec;
               miner_reset <= 1'b1;
               state       <= CLEAR;
            end
            DONE: begin
               exhausted <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench: a 2-lane and a 4-lane scheduler, each around a behavioural array
// that raises done a fixed number of cycles after start.
module tb_nonce_scheduler;

   localparam int LAT = 3;

   typedef struct packed {
      logic [31:0]  nonce;
      logic [255:0] hash;
   } hit_t;

   logic clk, reset_n, job_valid, abort, found_ready, sel4;
   logic [31:0]  version, timestamp, bits, nonce_start, nonce_end;
   logic [255:0] prev_blk, merkle;

   // 2-lane instance
   logic         jr2, ms2, mr2, fv2, busy2, exh2;
   logic [31:0]  hv2, ht2, hb2, fn2;
   logic [255:0] hp2, hm2, fh2;
   logic [63:0]  mn2;
   logic [511:0] mh2;
   logic         md2;
   int           cnt2;
   // 4-lane instance
   logic         jr4, ms4, mr4, fv4, busy4, exh4;
   logic [31:0]  hv4, ht4, hb4, fn4;
   logic [255:0] hp4, hm4, fh4;
   logic [127:0] mn4;
   logic [1023:0] mh4;
   logic         md4;
   int           cnt4;

   logic [31:0] win_q[$];
   logic        zero_mode;
   hit_t        exp_q[$];
   int          n_checks, n_errors, exh_cnt, clr_cnt, exh0, clr0;

   nonce_scheduler #(.NUM_HASHERS(2)) dut (
      .clk(clk), .reset_n(reset_n), .job_valid(job_valid && !sel4), .job_ready(jr2),
      .version(version), .hashPrevBlock(prev_blk), .hashMerkleRoot(merkle),
      .timestamp(timestamp), .bits(bits), .nonce_start(nonce_start), .nonce_end(nonce_end),
      .abort(abort), .hdr_version(hv2), .hdr_hashPrevBlock(hp2), .hdr_hashMerkleRoot(hm2),
      .hdr_timestamp(ht2), .hdr_bits(hb2), .miner_nonce(mn2), .miner_start(ms2),
      .miner_reset(mr2), .miner_done(md2), .miner_hash(mh2), .found_valid(fv2),
      .found_ready(found_ready), .found_nonce(fn2), .found_hash(fh2), .busy(busy2),
      .exhausted(exh2));

   nonce_scheduler #(.NUM_HASHERS(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .job_valid(job_valid && sel4), .job_ready(jr4),
      .version(version), .hashPrevBlock(prev_blk), .hashMerkleRoot(merkle),
      .timestamp(timestamp), .bits(bits), .nonce_start(nonce_start), .nonce_end(nonce_end),
      .abort(abort && sel4), .hdr_version(hv4), .hdr_hashPrevBlock(hp4), .hdr_hashMerkleRoot(hm4),
      .hdr_timestamp(ht4), .hdr_bits(hb4), .miner_nonce(mn4), .miner_start(ms4),
      .miner_reset(mr4), .miner_done(md4), .miner_hash(mh4), .found_valid(fv4),
      .found_ready(found_ready), .found_nonce(fn4), .found_hash(fh4), .busy(busy4),
      .exhausted(exh4));

   // Observed view of whichever instance the current test targets.
   wire          m_fv    = sel4 ? fv4 : fv2;
   wire [31:0]   m_fn    = sel4 ? fn4 : fn2;
   wire [255:0]  m_fh    = sel4 ? fh4 : fh2;
   wire          m_exh   = sel4 ? exh4 : exh2;
   wire          m_mr    = sel4 ? mr4 : mr2;
   wire          m_ms    = sel4 ? ms4 : ms2;
   wire          m_busy  = sel4 ? busy4 : busy2;
   wire          m_jr    = sel4 ? jr4 : jr2;
   wire [31:0]   m_hb    = sel4 ? hb4 : hb2;
   wire [31:0]   m_hv    = sel4 ? hv4 : hv2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digest model: winners get their own nonce as digest, everything else all-ones.
   function automatic logic [255:0] hash_of(input logic [31:0] n);
      if (zero_mode) return '0;
      foreach (win_q[k]) if (win_q[k] == n) return {224'd0, n};
      return '1;
   endfunction

   // Independent target model: repeated byte multiply/divide instead of shifts.
   function automatic logic [255:0] tb_target(input logic [31:0] b);
      logic [255:0] t;
      int e;
      t = {232'd0, b[23:0]};
      e = int'(b[31:24]);
      if (e >= 3) for (int k = 3; k < e; k++) t = t * 256;
      else        for (int k = e; k < 3; k++) t = t / 256;
      return t;
   endfunction

   function automatic int exp_batches(input logic [31:0] s, input logic [31:0] e, input int n);
      longint b;
      if (e < s) return 0;
      b = longint'(s);
      for (int k = 1; k < 100000; k++) begin
         if (b + n - 1 >= longint'(e)) return k;
         b = b + n;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (mr2) begin
         md2 <= 1'b0; cnt2 <= 0;
      end else if (ms2 && !md2) begin
         cnt2 <= cnt2 + 1;
         if (cnt2 == LAT - 1) begin
            md2 <= 1'b1;
            for (int i = 0; i < 2; i++) mh2[i*256 +: 256] <= hash_of(mn2[i*32 +: 32]);
         end
      end
   end

   always @(posedge clk) begin
      if (mr4) begin
         md4 <= 1'b0; cnt4 <= 0;
      end else if (ms4 && !md4) begin
         cnt4 <= cnt4 + 1;
         if (cnt4 == LAT - 1) begin
            md4 <= 1'b1;
            for (int i = 0; i < 4; i++) mh4[i*256 +: 256] <= hash_of(mn4[i*32 +: 32]);
         end
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Push expected hits, snapshot counters and present the job for one accepting edge.
   task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [31:0] e);
      hit_t h;
      for (longint n = longint'(s); n <= longint'(e); n++) begin
         h.nonce = n[31:0];
         h.hash  = hash_of(n[31:0]);
         if (!b[23] && h.hash <= tb_target(b)) exp_q.push_back(h);
      end
      exh0 = exh_cnt;
      clr0 = clr_cnt;
      @(posedge clk); #1;
      bits = b; nonce_start = s; nonce_end = e;
      version = $urandom; timestamp = $urandom;
      job_valid = 1'b1;
      @(posedge clk); #1;
      job_valid = 1'b0;
   endtask

   task automatic finish_job(input int exp_clears);
      for (int c = 0; c < 400 && exh_cnt == exh0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("exhausted_pulses", 256'(exh_cnt - exh0), 256'd1);
      check("hits_left", 256'(exp_q.size()), 256'd0);
      check("clear_pulses", 256'(clr_cnt - clr0), 256'(exp_clears));
   endtask

   task automatic wait_found();
      for (int c = 0; c < 200 && !m_fv; c++) @(negedge clk);
      check("found_valid_seen", 256'(m_fv), 256'd1);
   endtask

   initial begin
      hit_t e;
      n_checks = 0; n_errors = 0; exh_cnt = 0; clr_cnt = 0; exh0 = 0; clr0 = 0;
      reset_n = 1'b0; job_valid = 1'b0; abort = 1'b0; found_ready = 1'b1; sel4 = 1'b0;
      zero_mode = 1'b0; version = '0; timestamp = '0; bits = '0;
      nonce_start = '0; nonce_end = '0; prev_blk = {8{32'h0123_4567}}; merkle = {8{32'h89ab_cdef}};

      fork
         forever begin
            @(negedge clk);
            if (reset_n) begin
               if (m_exh) exh_cnt++;
               if (m_mr && m_busy && !m_exh) clr_cnt++;
               if (m_fv && found_ready) begin
                  check("hit_expected", 256'(exp_q.size() > 0), 256'd1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check("found_nonce", 256'(m_fn), 256'(e.nonce));
                     check("found_hash", m_fh, e.hash);
                  end
               end
            end
         end
      join_none

      // Reset values
      #12;
      check("rst_job_ready", 256'(jr2), 256'd1);
      check("rst_miner_reset", 256'(mr2), 256'd1);
      check("rst_miner_start", 256'(ms2), 256'd0);
      check("rst_found_valid", 256'(fv2), 256'd0);
      check("rst_busy", 256'(busy2), 256'd0);
      check("rst_exhausted", 256'(exh2), 256'd0);
      check("rst_miner_nonce", 256'(mn2), 256'd0);
      check("rst_found_hash", fh2, 256'd0);
      check("rst_hdr_bits", 256'(hb2), 256'd0);
      @(posedge clk); #1 reset_n = 1'b1;

      // Test 1: one winner in lane 1 of batch 0, two batches
      win_q = '{32'd1};
      start_job(32'h207fffff, 32'd0, 32'd3);
      @(negedge clk);
      check("hdr_bits_latched", 256'(m_hb), 256'(bits));
      check("hdr_version_latched", 256'(m_hv), 256'(version));
      finish_job(2);

      // Test 2: negative compact target, all-zero digests never hit
      zero_mode = 1'b1;
      start_job(32'h1d800000, 32'd0, 32'd3);
      finish_job(2);

      // Partial last batch: nonce 3 would win but lies past the range end
      zero_mode = 1'b0;
      win_q = '{32'd2, 32'd3};
      start_job(32'h207fffff, 32'd0, 32'd2);
      finish_job(2);

      // Empty range goes straight to the exhausted pulse
      start_job(32'h207fffff, 32'd5, 32'd4);
      finish_job(0);

      // Small exponent path: target = 0x12 (m >> 16), nonce 0x12 hits, 0x13 does not
      win_q = '{32'h12, 32'h13};
      start_job(32'h01123456, 32'h10, 32'h13);
      finish_job(exp_batches(32'h10, 32'h13, 2));

      // Test 3: 4 lanes at the top of the nonce space, wrapped lanes masked
      sel4 = 1'b1;
      zero_mode = 1'b1;
      start_job(32'h207fffff, 32'hFFFFFFFE, 32'hFFFFFFFF);
      finish_job(exp_batches(32'hFFFFFFFE, 32'hFFFFFFFF, 4));
      sel4 = 1'b0;
      zero_mode = 1'b0;

      // Test 4: both lanes win, consumer stalls for 5 cycles
      win_q = '{32'd0, 32'd1};
      @(posedge clk); #1 found_ready = 1'b0;
      start_job(32'h207fffff, 32'd0, 32'd1);
      wait_found();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_valid", 256'(m_fv), 256'd1);
         check("stall_nonce", 256'(m_fn), 256'd0);
      end
      @(posedge clk); #1 found_ready = 1'b1;
      finish_job(1);

      // Abort in IDLE is ignored and blocks accept
      @(posedge clk); #1 job_valid = 1'b1; abort = 1'b1;
      @(posedge clk); #1 job_valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("idle_abort_blocks", 256'(m_busy), 256'd0);

      // Test 5: abort while the array runs
      win_q.delete();
      exh0 = exh_cnt;
      start_job(32'h207fffff, 32'd0, 32'd3);
      for (int c = 0; c < 50 && !m_ms; c++) @(negedge clk);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("abort_miner_start", 256'(m_ms), 256'd0);
      check("abort_miner_reset", 256'(m_mr), 256'd1);
      check("abort_job_ready", 256'(m_jr), 256'd1);
      repeat (20) @(negedge clk);
      check("abort_no_exhausted", 256'(exh_cnt - exh0), 256'd0);

      // Test 6: asynchronous reset in REPORT
      win_q = '{32'd0};
      found_ready = 1'b0;
      start_job(32'h207fffff, 32'd0, 32'd1);
      wait_found();
      #2 reset_n = 1'b0;
      #1;
      check("arst_found_valid", 256'(m_fv), 256'd0);
      check("arst_miner_reset", 256'(m_mr), 256'd1);
      check("arst_found_nonce", 256'(m_fn), 256'd0);
      exp_q.delete();
      found_ready = 1'b1;
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("arst_job_ready", 256'(m_jr), 256'd1);
      check("arst_busy", 256'(m_busy), 256'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
